// File: rtl/ee354_detour_sweep.sv
// ee354_detour_sweep: N-lamp arrow-bar controller. The bar fills step by step
// toward the selected side, then blanks and repeats. A hazard request flashes
// all lamps instead. A step timer paces every state, and Run freezes the
// timer and the FSM. Done pulses for one cycle after each completed sweep.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | all lamps off; direction/hazard sampled when it ends
//   SWEEP     | bar lit up to Step lamps toward the latched direction
//   FLASH_ON  | hazard flash, all lamps on
//   FLASH_OFF | hazard flash, all lamps off, then back to IDLE

module ee354_detour_sweep #(
    parameter  int N_LAMPS = 4,
    parameter  int DWELL   = 1,
    localparam int STEP_W  = $clog2(N_LAMPS + 1)
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              Run,
    input  logic              L_Rbar,
    input  logic              Hazard,
    output logic [N_LAMPS-1:0] Lamps,
    output logic              q_Idle,
    output logic              q_Sweep,
    output logic              q_FlashOn,
    output logic              q_FlashOff,
    output logic [STEP_W-1:0] Step,
    output logic              Dir,
    output logic              Done
);

    // DWELL=1 still needs a one-bit timer so the compare below stays legal.
    localparam int TMR_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(DWELL - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_LAMPS);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    localparam logic [3:0] S_IDLE      = 4'b0001;
    localparam logic [3:0] S_SWEEP     = 4'b0010;
    localparam logic [3:0] S_FLASH_ON  = 4'b0100;
    localparam logic [3:0] S_FLASH_OFF = 4'b1000;

    logic [TMR_W-1:0]  tmr;
    logic              tick;
    logic [3:0]        state_q;
    logic [3:0]        state_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic              dir_q;
    logic              dir_d;
    logic              done_q;
    logic              done_d;
    logic [N_LAMPS-1:0] lamps_d;

    // A tick only happens on a Run cycle, so a Run drop on the terminal
    // count suppresses that transition until Run returns.
    assign tick = Run && (tmr == TMR_LAST);

    // Step timer: counts 0..DWELL-1 while running, holds while paused.
    always_ff @(posedge Clk) begin
        if (reset) begin
            tmr <= '0;
        end else if (Run) begin
            if (tick) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + 1'b1;
            end
        end
    end

    // State register together with the step index, latched direction and
    // the registered Done pulse.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: transitions only on tick, except that any encoding
    // that is not one of the four legal one-hot codes recovers to IDLE at once.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    if (Hazard) begin
                        state_d = S_FLASH_ON;
                    end else begin
                        state_d = S_SWEEP;
                        step_d  = STEP_ONE;
                        dir_d   = L_Rbar;
                    end
                end
            end
            S_SWEEP: begin
                if (tick) begin
                    if (step_q == STEP_LAST) begin
                        state_d = S_IDLE;
                        step_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        step_d = step_q + STEP_ONE;
                    end
                end
            end
            S_FLASH_ON: begin
                if (tick) begin
                    state_d = S_FLASH_OFF;
                end
            end
            S_FLASH_OFF: begin
                if (tick) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Lamp decode from registered state only, so Lamps cannot glitch with
    // the direction or hazard inputs.
    always_comb begin
        lamps_d = '0;
        case (state_q)
            S_SWEEP: begin
                for (int i = 0; i < N_LAMPS; i++) begin
                    if (dir_q) begin
                        lamps_d[i] = (i < int'(step_q));
                    end else begin
                        lamps_d[i] = (i >= (N_LAMPS - int'(step_q)));
                    end
                end
            end
            S_FLASH_ON: begin
                lamps_d = '1;
            end
            default: begin
                lamps_d = '0;
            end
        endcase
    end

    // Output flags and registered status; exact-match flags stay all-zero
    // rather than multi-hot during the single illegal-recovery cycle.
    always_comb begin
        Lamps      = lamps_d;
        q_Idle     = (state_q == S_IDLE);
        q_Sweep    = (state_q == S_SWEEP);
        q_FlashOn  = (state_q == S_FLASH_ON);
        q_FlashOff = (state_q == S_FLASH_OFF);
        Step       = step_q;
        Dir        = dir_q;
        Done       = done_q;
    end

endmodule

// File: tb/tb_ee354_detour_sweep.sv
// Bench for ee354_detour_sweep: three instances (N=4/DWELL=1, N=6/DWELL=2,
// N=4/DWELL=3) each with their own inputs. Expectations are queued when the
// inputs for a cycle are driven and drained just after the following edge.

module tb_ee354_detour_sweep;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic rst_v [3];
    logic run_v [3];
    logic lr_v  [3];
    logic hz_v  [3];

    logic [3:0] lamps_a;
    logic [5:0] lamps_b;
    logic [3:0] lamps_c;
    logic [2:0] step_a, step_b, step_c;
    logic id_a, sw_a, fn_a, fo_a, dir_a, done_a;
    logic id_b, sw_b, fn_b, fo_b, dir_b, done_b;
    logic id_c, sw_c, fn_c, fo_c, dir_c, done_c;

    ee354_detour_sweep #(.N_LAMPS(4), .DWELL(1)) u_a (
        .Clk(Clk), .reset(rst_v[0]), .Run(run_v[0]), .L_Rbar(lr_v[0]), .Hazard(hz_v[0]),
        .Lamps(lamps_a), .q_Idle(id_a), .q_Sweep(sw_a), .q_FlashOn(fn_a), .q_FlashOff(fo_a),
        .Step(step_a), .Dir(dir_a), .Done(done_a));

    ee354_detour_sweep #(.N_LAMPS(6), .DWELL(2)) u_b (
        .Clk(Clk), .reset(rst_v[1]), .Run(run_v[1]), .L_Rbar(lr_v[1]), .Hazard(hz_v[1]),
        .Lamps(lamps_b), .q_Idle(id_b), .q_Sweep(sw_b), .q_FlashOn(fn_b), .q_FlashOff(fo_b),
        .Step(step_b), .Dir(dir_b), .Done(done_b));

    ee354_detour_sweep #(.N_LAMPS(4), .DWELL(3)) u_c (
        .Clk(Clk), .reset(rst_v[2]), .Run(run_v[2]), .L_Rbar(lr_v[2]), .Hazard(hz_v[2]),
        .Lamps(lamps_c), .q_Idle(id_c), .q_Sweep(sw_c), .q_FlashOn(fn_c), .q_FlashOff(fo_c),
        .Step(step_c), .Dir(dir_c), .Done(done_c));

    // Packed view: [17:10] lamps, [9:6] flags {off,on,sweep,idle}, [5:2] step, [1] dir, [0] done
    localparam int ALL_M  = 32'h3FFFF;
    localparam int LAMP_M = 32'h3FC00;
    localparam int STEP_M = 32'h0003C;

    typedef struct {
        string tag;
        int    inst;
        int    mask;
        int    exp;
    } sb_t;

    sb_t sbq[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    int NL [3] = '{4, 6, 4};
    int DW [3] = '{1, 2, 3};

    // Reference model: st 0=idle 1=sweep 2=flash on 3=flash off
    int m_st [3];
    int m_step [3];
    int m_dir [3];
    int m_done [3];
    int m_tmr [3];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int obs_pack(input int i);
        case (i)
            0: return (int'(lamps_a) << 10) | (int'({fo_a, fn_a, sw_a, id_a}) << 6) |
                      (int'(step_a) << 2) | (int'(dir_a) << 1) | int'(done_a);
            1: return (int'(lamps_b) << 10) | (int'({fo_b, fn_b, sw_b, id_b}) << 6) |
                      (int'(step_b) << 2) | (int'(dir_b) << 1) | int'(done_b);
            default: return (int'(lamps_c) << 10) | (int'({fo_c, fn_c, sw_c, id_c}) << 6) |
                      (int'(step_c) << 2) | (int'(dir_c) << 1) | int'(done_c);
        endcase
    endfunction

    function automatic int model_pack(input int i);
        int lamps;
        lamps = 0;
        if (m_st[i] == 1) begin
            for (int j = 0; j < NL[i]; j++) begin
                if (m_dir[i] != 0 ? (j < m_step[i]) : (j >= NL[i] - m_step[i]))
                    lamps = lamps | (1 << j);
            end
        end else if (m_st[i] == 2) begin
            lamps = (1 << NL[i]) - 1;
        end
        return (lamps << 10) | ((1 << m_st[i]) << 6) | (m_step[i] << 2) | (m_dir[i] << 1) | m_done[i];
    endfunction

    // Advances model instance i by one edge using the inputs now driven.
    task automatic model_update(input int i);
        bit tk;
        if (rst_v[i]) begin
            m_st[i] = 0; m_step[i] = 0; m_dir[i] = 0; m_done[i] = 0; m_tmr[i] = 0;
        end else begin
            tk = run_v[i] && (m_tmr[i] == DW[i] - 1);
            m_done[i] = 0;
            if (run_v[i]) m_tmr[i] = tk ? 0 : m_tmr[i] + 1;
            if (tk) begin
                case (m_st[i])
                    0: begin
                        if (hz_v[i]) m_st[i] = 2;
                        else begin m_st[i] = 1; m_step[i] = 1; m_dir[i] = int'(lr_v[i]); end
                    end
                    1: begin
                        if (m_step[i] == NL[i]) begin m_st[i] = 0; m_step[i] = 0; m_done[i] = 1; end
                        else m_step[i] = m_step[i] + 1;
                    end
                    2: m_st[i] = 3;
                    default: m_st[i] = 0;
                endcase
            end
        end
    endtask

    // Literal expectation on lamps/step/done for the next edge.
    task automatic lit(input string tag, input int inst, input int lamps, input int step, input int done);
        sb_t e;
        e.tag = tag; e.inst = inst; e.mask = LAMP_M | STEP_M | 1;
        e.exp = (lamps << 10) | (step << 2) | done;
        sbq.push_back(e);
    endtask

    task automatic lit_full(input string tag, input int inst, input int exp);
        sb_t e;
        e.tag = tag; e.inst = inst; e.mask = ALL_M; e.exp = exp;
        sbq.push_back(e);
    endtask

    // One clock: queue model expectations, take the edge, drain the queue.
    task automatic cycle();
        sb_t e;
        for (int i = 0; i < 3; i++) begin
            model_update(i);
            e.tag = $sformatf("model%0d", i); e.inst = i; e.mask = ALL_M; e.exp = model_pack(i);
            sbq.push_back(e);
        end
        @(posedge Clk);
        #1;
        cyc++;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, obs_pack(e.inst) & e.mask, e.exp);
        end
    endtask

    task automatic set_all(input logic rst, input logic run, input logic hz);
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = rst; run_v[i] = run; hz_v[i] = hz;
        end
    endtask

    int a_lamps [7] = '{0, 1, 3, 7, 15, 0, 1};
    int a_step  [7] = '{0, 1, 2, 3, 4, 0, 1};
    int c_pat   [5] = '{0, 8, 12, 14, 15};

    initial begin
        set_all(1'b1, 1'b1, 1'b0);
        lr_v[0] = 1'b1; lr_v[1] = 1'b0; lr_v[2] = 1'b0;

        // Reset held two cycles, then left sweep on A, right sweep on C,
        // and L_Rbar toggling every cycle on B.
        cycle();
        lit("a_rst", 0, 0, 0, 0);
        lit("c_rst", 2, 0, 0, 0);
        cycle();
        set_all(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            lr_v[1] = k[0];
            if (k <= 6) lit($sformatf("a_fill%0d", k), 0, a_lamps[k], a_step[k], (k == 5) ? 1 : 0);
            if (k <= 2 || k == 16 || k == 17) lit($sformatf("c_idle%0d", k), 2, 0, 0, 0);
            else if (k <= 14) lit($sformatf("c_fill%0d", k), 2, c_pat[(k - 3) / 3 + 1], (k - 3) / 3 + 1, 0);
            else if (k == 15) lit("c_done", 2, 0, 0, 1);
            else if (k == 18) lit("c_again", 2, 8, 1, 0);
            cycle();
        end

        // Run low for five cycles at Step=2 on A; C loses its tick to Run low.
        set_all(1'b1, 1'b1, 1'b0);
        lr_v[0] = 1'b1;
        cycle();
        rst_v[0] = 1'b0; rst_v[1] = 1'b0; rst_v[2] = 1'b0;
        cycle();
        lit("a_step2", 0, 3, 2, 0);
        cycle();
        run_v[0] = 1'b0; run_v[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            lit($sformatf("a_hold%0d", k), 0, 3, 2, 0);
            lit($sformatf("c_hold%0d", k), 2, 0, 0, 0);
            cycle();
        end
        run_v[0] = 1'b1; run_v[2] = 1'b1;
        lit("a_resume", 0, 7, 3, 0);
        cycle();
        for (int k = 0; k < 12; k++) cycle();

        // Hazard flash on every instance; B gives 2/2/2 cycles of off/on/off.
        set_all(1'b1, 1'b1, 1'b1);
        lit("b_hz0", 1, 0, 0, 0);
        cycle();
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            lit($sformatf("b_hz%0d", k), 1, (((k % 6) / 2) == 1) ? 63 : 0, 0, 0);
            cycle();
        end

        // Reset for one cycle mid-sweep: A left at Step=4, C right at Step=3.
        set_all(1'b1, 1'b1, 1'b0);
        lr_v[0] = 1'b1; lr_v[2] = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        for (int k = 1; k <= 9; k++) cycle();
        rst_v[0] = 1'b1; rst_v[2] = 1'b1;
        lit_full("a_midrst", 0, 1 << 6);
        lit_full("c_midrst", 2, 1 << 6);
        cycle();
        rst_v[0] = 1'b0; rst_v[2] = 1'b0;
        for (int k = 0; k < 20; k++) cycle();

        // Random direction/hazard traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                rst_v[i] = ($urandom_range(0, 49) == 0);
                lr_v[i]  = 1'($urandom_range(0, 1));
                hz_v[i]  = ($urandom_range(0, 3) == 0);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
